// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: sequences one load / capture / unload pass over a scan chain
// of CHAIN_LEN flops. Patterns arrive and responses leave on valid/ready
// handshakes; every output is a decode of registered state.
module scan_chain_ctrl #(
  parameter int       CHAIN_LEN = 8,
  parameter int       CNT_W     = 4,
  parameter bit       FILL_BIT  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 abort,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_data,
  output logic                 scan_en,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [CHAIN_LEN-1:0] resp_data,
  output logic                 busy,
  output logic [15:0]          pat_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CAPTURE,
    UNLOAD,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] sh_q, sh_d;
  logic [CHAIN_LEN-1:0] resp_q, resp_d;
  logic [15:0]          pat_cnt_r, pat_cnt_d;

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      resp_q    <= '0;
      pat_cnt_r <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      resp_q    <= resp_d;
      pat_cnt_r <= pat_cnt_d;
    end
  end

  // Next-state and datapath updates; abort outranks every handshake.
  always_comb begin
    // NOTE: every signal gets a hold default first, so no path through the
    // case can leave one unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    resp_d    = resp_q;
    pat_cnt_d = pat_cnt_r;

    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // An abort in IDLE blocks acceptance of the pattern on offer.
          if (pat_valid && !abort) begin
            sh_d    = pat_data;
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          sh_d = {sh_q[CHAIN_LEN-2:0], 1'b0};
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = CAPTURE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        CAPTURE: begin
          cnt_d   = '0;
          state_d = UNLOAD;
        end
        UNLOAD: begin
          // First bit out is flop CHAIN_LEN-1, so it lands in the MSB.
          resp_d = {resp_q[CHAIN_LEN-2:0], scan_out};
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (resp_ready) begin
            pat_cnt_d = pat_cnt_r + 16'd1;
            cnt_d     = '0;
            state_d   = IDLE;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // Moore output decode from registered state only.
  always_comb begin
    pat_ready  = (state_q == IDLE);
    busy       = (state_q != IDLE);
    scan_en    = (state_q == SHIFT) || (state_q == UNLOAD);
    resp_valid = (state_q == DONE);
    resp_data  = resp_q;
    pat_cnt    = pat_cnt_r;
    scan_in    = 1'b0;
    if (state_q == SHIFT)       scan_in = sh_q[CHAIN_LEN-1];
    else if (state_q == UNLOAD) scan_in = FILL_BIT;
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: directed bench for scan_chain_ctrl with an 8-flop chain
// whose functional D is ~Q, a phase-count reference model checked every cycle,
// and literal expectations for the documented scenarios.
module tb_scan_chain_ctrl;

  localparam int CL = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          abort = 1'b0;
  logic          pat_valid = 1'b0;
  logic          pat_ready;
  logic [CL-1:0] pat_data = '0;
  logic          scan_en;
  logic          scan_in;
  logic          scan_out;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [CL-1:0] resp_data;
  logic          busy;
  logic [15:0]   pat_cnt;

  int checks = 0;
  int failures = 0;

  scan_chain_ctrl #(.CHAIN_LEN(CL), .CNT_W(4), .FILL_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .abort(abort),
    .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_data(pat_data),
    .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy), .pat_cnt(pat_cnt)
  );

  always #5 clk = ~clk;

  // Scan chain: shift when scan_en, else capture functional D = ~Q.
  logic [CL-1:0] chain = '0;
  always @(posedge clk) chain <= scan_en ? {chain[CL-2:0], scan_in} : ~chain;
  assign scan_out = chain[CL-1];

  // Reference model: phase = cycles since accept (0 idle, 1..8 shift,
  // 9 capture, 10..17 unload, 18 waiting for response handshake).
  int            m_phase = 0;
  logic [CL-1:0] m_pat = '0;
  logic [15:0]   m_pat_cnt = '0;
  bit            started = 1'b0;
  bit            preload_req = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase   <= 0;
      m_pat_cnt <= '0;
      started   <= 1'b1;
    end else begin
      if (preload_req) m_pat_cnt <= 16'hFFFF;
      if (m_phase == 0) begin
        if (pat_valid && !abort) begin
          m_phase <= 1;
          m_pat   <= pat_data;
        end
      end else if (abort) begin
        m_phase <= 0;
      end else if (m_phase < 2*CL+2) begin
        m_phase <= m_phase + 1;
      end else if (resp_ready) begin
        m_phase   <= 0;
        m_pat_cnt <= m_pat_cnt + 16'd1;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (started) begin
      logic e_ready, e_busy, e_en, e_in, e_rv, ok;
      e_ready = (m_phase == 0);
      e_busy  = (m_phase != 0);
      e_en    = (m_phase >= 1 && m_phase <= CL) || (m_phase >= CL+2 && m_phase <= 2*CL+1);
      e_in    = (m_phase >= 1 && m_phase <= CL) ? m_pat[CL-m_phase] : 1'b0;
      e_rv    = (m_phase == 2*CL+2);
      ok = (pat_ready === e_ready) && (busy === e_busy) && (scan_en === e_en) &&
           (scan_in === e_in) && (resp_valid === e_rv) && (pat_cnt === m_pat_cnt) &&
           (!e_rv || resp_data === ~m_pat);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t phase=%0d got rdy=%b busy=%b en=%b in=%b rv=%b rd=%h cnt=%h want rdy=%b busy=%b en=%b in=%b rv=%b rd=%h cnt=%h",
                 $time, m_phase, pat_ready, busy, scan_en, scan_in, resp_valid, resp_data, pat_cnt,
                 e_ready, e_busy, e_en, e_in, e_rv, ~m_pat, m_pat_cnt);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; abort = 1'b0; pat_valid = 1'b0; resp_ready = 1'b0; pat_data = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 60 && !pat_ready; i++) step();
    check("pat_ready_timeout", 32'(pat_ready), 32'd1);
  endtask

  task automatic wait_resp();
    for (int i = 0; i < 60 && !resp_valid; i++) step();
    check("resp_valid_timeout", 32'(resp_valid), 32'd1);
  endtask

  // Full pass with resp_ready=1; checks the returned response.
  task automatic run_pattern(input logic [CL-1:0] pat, input logic [CL-1:0] exp, input string name);
    resp_ready = 1'b1;
    pat_data   = pat;
    pat_valid  = 1'b1;
    wait_ready();
    step();
    pat_valid = 1'b0;
    wait_resp();
    check(name, 32'(resp_data), 32'(exp));
    step();
  endtask

  initial begin
    logic [CL-1:0] seq;
    logic [CL-1:0] pats [3];
    logic [CL-1:0] exps [3];
    int            low_cnt, low_at;
    bit            stable, saw_rv;

    // 1: reset mid-SHIFT
    do_reset();
    check("rst_pat_ready", 32'(pat_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    run_pattern(8'h0F, 8'hF0, "pre_reset_resp");
    check("pre_reset_cnt", 32'(pat_cnt), 32'd1);
    pat_data = 8'hA5; pat_valid = 1'b1;
    step();
    pat_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step(); step();
    check("midshift_scan_en", 32'(scan_en), 32'd0);
    check("midshift_busy", 32'(busy), 32'd0);
    check("midshift_pat_ready", 32'(pat_ready), 32'd1);
    check("midshift_pat_cnt", 32'(pat_cnt), 32'd0);
    rst = 1'b0;

    // 2: single pattern, cycle-exact
    do_reset();
    resp_ready = 1'b1; pat_data = 8'hA5; pat_valid = 1'b1;
    step();
    pat_valid = 1'b0;
    seq = '0; low_cnt = 0; low_at = 0;
    for (int k = 1; k <= 2*CL+1; k++) begin
      if (k <= CL) seq = {seq[CL-2:0], scan_in};
      if (!scan_en) begin low_cnt++; low_at = k; end
      step();
    end
    check("single_scan_in_seq", 32'(seq), 32'hA5);
    check("single_scan_en_low_cnt", 32'(low_cnt), 32'd1);
    check("single_scan_en_low_at", 32'(low_at), 32'd9);
    check("single_resp_valid_c18", 32'(resp_valid), 32'd1);
    check("single_resp_data", 32'(resp_data), 32'h5A);
    step();
    check("single_pat_cnt", 32'(pat_cnt), 32'd1);
    check("single_idle", 32'(busy), 32'd0);

    // 3: backpressure in DONE
    do_reset();
    pat_data = 8'hA5; pat_valid = 1'b1;
    wait_ready();
    step();
    pat_valid = 1'b0;
    wait_resp();
    pat_valid = 1'b1; pat_data = 8'hFF;
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (resp_data !== 8'h5A || resp_valid !== 1'b1 || pat_ready !== 1'b0) stable = 1'b0;
      step();
    end
    check("bp_stable", 32'(stable), 32'd1);
    check("bp_resp_data", 32'(resp_data), 32'h5A);
    resp_ready = 1'b1; pat_valid = 1'b0;
    step();
    check("bp_idle", 32'(busy), 32'd0);
    check("bp_pat_cnt", 32'(pat_cnt), 32'd1);

    // 4: back-to-back with pat_valid held high
    do_reset();
    pats[0] = 8'h00; pats[1] = 8'hFF; pats[2] = 8'h3C;
    exps[0] = 8'hFF; exps[1] = 8'h00; exps[2] = 8'hC3;
    resp_ready = 1'b1; pat_valid = 1'b1;
    for (int idx = 0; idx < 3; idx++) begin
      pat_data = pats[idx];
      wait_ready();
      step();
      if (idx == 2) pat_valid = 1'b0;
      wait_resp();
      check($sformatf("b2b_resp_%0d", idx), 32'(resp_data), 32'(exps[idx]));
      check($sformatf("b2b_no_accept_%0d", idx), 32'(pat_ready), 32'd0);
      step();
    end
    check("b2b_pat_cnt", 32'(pat_cnt), 32'd3);

    // 5: abort at SHIFT cycle 4, then abort in IDLE, then a clean pattern
    do_reset();
    resp_ready = 1'b1; pat_data = 8'h5A; pat_valid = 1'b1;
    step();
    pat_valid = 1'b0;
    step(); step(); step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_scan_en", 32'(scan_en), 32'd0);
    check("abort_pat_ready", 32'(pat_ready), 32'd1);
    saw_rv = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (resp_valid) saw_rv = 1'b1;
      step();
    end
    check("abort_no_resp", 32'(saw_rv), 32'd0);
    check("abort_pat_cnt", 32'(pat_cnt), 32'd0);
    abort = 1'b1; pat_valid = 1'b1; pat_data = 8'h81;
    step();
    abort = 1'b0; pat_valid = 1'b0;
    check("abort_idle_no_accept", 32'(busy), 32'd0);
    run_pattern(8'h81, 8'h7E, "abort_next_resp");
    check("abort_next_cnt", 32'(pat_cnt), 32'd1);

    // 6: pat_cnt wrap from a preloaded 0xFFFF
    do_reset();
    preload_req = 1'b1;
    @(negedge clk);
    #1;
    force dut.pat_cnt_r = 16'hFFFF;
    step();
    release dut.pat_cnt_r;
    preload_req = 1'b0;
    check("wrap_preload", 32'(pat_cnt), 32'hFFFF);
    run_pattern(8'hC3, 8'h3C, "wrap_resp");
    check("wrap_pat_cnt", 32'(pat_cnt), 32'd0);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
